// File: rtl/nxs_skein_work_sched_if.sv
// nxs_skein_work_sched_if: work-in, pipeline and found-nonce signal bundle (hit_count with NXS_SKEIN_SCHED_HITCNT_EN)
interface nxs_skein_work_sched_if;
  logic work_valid, work_ready, stop, found_valid, found_ready, busy, overflow;
  logic [639:0] work_state, pipe_state;
  logic [1087:0] work_key, pipe_key;
  logic [63:0] work_nonce, work_target, pipe_nonce, pipe_result, found_nonce;
`ifdef NXS_SKEIN_SCHED_HITCNT_EN
  logic [31:0] hit_count;
  modport master (
    output work_valid, work_state, work_key, work_nonce, work_target, stop, pipe_result, found_ready,
    input work_ready, pipe_state, pipe_key, pipe_nonce, found_valid, found_nonce, busy, overflow, hit_count
  );
  modport slave (
    input work_valid, work_state, work_key, work_nonce, work_target, stop, pipe_result, found_ready,
    output work_ready, pipe_state, pipe_key, pipe_nonce, found_valid, found_nonce, busy, overflow, hit_count
  );
`else
  modport master (
    output work_valid, work_state, work_key, work_nonce, work_target, stop, pipe_result, found_ready,
    input work_ready, pipe_state, pipe_key, pipe_nonce, found_valid, found_nonce, busy, overflow
  );
  modport slave (
    input work_valid, work_state, work_key, work_nonce, work_target, stop, pipe_result, found_ready,
    output work_ready, pipe_state, pipe_key, pipe_nonce, found_valid, found_nonce, busy, overflow
  );
`endif
endinterface

// File: rtl/nxs_skein_work_sched.sv
// nxs_skein_work_sched: Skein-1024 nonce scheduler with tag tracking, target check and found-nonce FIFO (NXS_SKEIN_SCHED_HITCNT_EN adds hit_count)
module nxs_skein_work_sched #(
  parameter int PIPE_LATENCY = 245,
  parameter int HASHERS      = 1,
  parameter int COREIDX      = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input logic clk,
  input logic nHashRst,
  nxs_skein_work_sched_if.slave bus
);
  localparam int CW = $clog2(PIPE_LATENCY + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam logic [63:0] STEP = 64'(HASHERS);
  localparam logic [63:0] BASE = 64'(COREIDX);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic accept, issue, busy, tag_out, hit_req, push, pop, full, drop, ready_q, ovf_q, ovf_d;
  logic [639:0] pstate_q;
  logic [1087:0] pkey_q;
  logic [63:0] nonce_q, nonce_d, rslt_q, rslt_d, target_q;
  logic [PIPE_LATENCY-1:0] tag_q, tag_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [63:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [FW-1:0] cnt_q, cnt_d;
  assign accept = bus.work_valid & ready_q;
  // state register
  always_ff @(posedge clk or negedge nHashRst)
    if (!nHashRst) state_q <= IDLE;
    else state_q <= state_d;
  // next state: a new work unit always wins, DRAIN ends once nothing is in flight
  always_comb
    state_d = accept ? RUN :
              (state_q == RUN && bus.stop) ? DRAIN :
              (state_q == DRAIN && infl_q == '0) ? IDLE : state_q;
  // FSM outputs: a slot is issued only in RUN when neither stopping nor reloading
  always_comb begin
    issue = state_q == RUN && !bus.stop && !accept;
    busy  = state_q != IDLE;
  end
  // tag pipeline, nonce counters, hit decision and FIFO bookkeeping
  always_comb begin
    tag_out = tag_q[PIPE_LATENCY-1];
    hit_req = tag_out && !accept && bus.pipe_result <= target_q;
    pop     = cnt_q != '0 && bus.found_ready;
    full    = cnt_q == FW'(FIFO_DEPTH);
    push    = hit_req && (!full || pop);
    drop    = hit_req && full && !pop;
    tag_d   = accept ? '0 : {tag_q[PIPE_LATENCY-2:0], issue};
    infl_d  = accept ? '0 : infl_q + CW'(issue) - CW'(tag_out);
    nonce_d = accept ? bus.work_nonce + BASE : issue ? nonce_q + STEP : nonce_q;
    rslt_d  = accept ? bus.work_nonce + BASE : tag_out ? rslt_q + STEP : rslt_q;
    cnt_d   = cnt_q + FW'(push) - FW'(pop);
    ovf_d   = accept ? 1'b0 : ovf_q | drop;
  end
  // datapath registers; the found FIFO deliberately survives a work reload
  always_ff @(posedge clk or negedge nHashRst)
    if (!nHashRst) begin
      ready_q  <= 1'b0;
      pstate_q <= '0;
      pkey_q   <= '0;
      target_q <= '0;
      nonce_q  <= '0;
      rslt_q   <= '0;
      tag_q    <= '0;
      infl_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        pstate_q <= bus.work_state;
        pkey_q   <= bus.work_key;
        target_q <= bus.work_target;
      end
      nonce_q <= nonce_d;
      rslt_q  <= rslt_d;
      tag_q   <= tag_d;
      infl_q  <= infl_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  // FIFO storage, validity tracked by cnt_q so no reset needed
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= rslt_q;
`ifdef NXS_SKEIN_SCHED_HITCNT_EN
  logic [31:0] hcnt_q, hcnt_d;
  // saturating hit counter, dropped hits included
  always_comb
    hcnt_d = accept ? '0 : (hit_req && hcnt_q != '1) ? hcnt_q + 32'd1 : hcnt_q;
  // hit counter register
  always_ff @(posedge clk or negedge nHashRst)
    if (!nHashRst) hcnt_q <= '0;
    else hcnt_q <= hcnt_d;
  assign bus.hit_count = hcnt_q;
`endif
  assign bus.work_ready  = ready_q;
  assign bus.pipe_state  = pstate_q;
  assign bus.pipe_key    = pkey_q;
  assign bus.pipe_nonce  = nonce_q;
  assign bus.found_valid = cnt_q != '0;
  assign bus.found_nonce = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign bus.busy        = busy;
  assign bus.overflow    = ovf_q;
endmodule
